// File: rtl/div24u_trunc_seq_if.sv
// Handshake bundle for the truncated-operand sequential divider:
// the operand request channel plus the quotient/flag response channel.
interface div24u_trunc_seq_if #(
    parameter int WZ = 24,
    parameter int WB = 12,
    parameter int WQ = 12
);
    logic          in_valid;
    logic          in_ready;
    logic [WZ-1:0] Z;
    logic [WB-1:0] B;
    logic          out_valid;
    logic          out_ready;
    logic [WQ-1:0] Q;
    logic          ovf;
    logic          dz;

    modport master (
        output in_valid, Z, B, out_ready,
        input  in_ready, out_valid, Q, ovf, dz
    );

    modport slave (
        input  in_valid, Z, B, out_ready,
        output in_ready, out_valid, Q, ovf, dz
    );
endinterface

// File: rtl/div24u_trunc_seq.sv
// Approximate unsigned divider: operand LSBs are zeroed, then an exact
// restoring division produces one quotient bit per clock, MSB first.
module div24u_trunc_seq #(
    parameter int WZ     = 24,
    parameter int WB     = 12,
    parameter int WQ     = 12,
    parameter int KEEP_Z = 10,
    parameter int KEEP_B = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    div24u_trunc_seq_if.slave   bus
);
    localparam int CW = $clog2(WQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WZ-1:0] ZMASK = {{KEEP_Z{1'b1}}, {(WZ-KEEP_Z){1'b0}}};
    localparam logic [WB-1:0] BMASK = {{KEEP_B{1'b1}}, {(WB-KEEP_B){1'b0}}};

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [WB:0]   rem_q,   rem_d;
    logic [WQ-1:0] zlo_q,   zlo_d;
    logic [WB-1:0] bt_q,    bt_d;
    logic [WQ-1:0] q_q,     q_d;
    logic          ovf_q,   ovf_d;
    logic          dz_q,    dz_d;

    logic [WZ-1:0] zt;
    logic [WB-1:0] bt;
    logic          sat_ovf;
    logic [WB:0]   trial;
    logic          ge;

    assign zt = bus.Z & ZMASK;
    assign bt = bus.B & BMASK;

    // Quotient fits in WQ bits only when the dividend's upper part is below the divisor.
    assign sat_ovf = {1'b0, zt} >= {1'b0, bt, {WQ{1'b0}}};

    assign trial = {rem_q[WB-1:0], zlo_q[WQ-1]};
    assign ge    = trial >= {1'b0, bt_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        zlo_d   = zlo_q;
        bt_d    = bt_q;
        q_d     = q_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    bt_d  = bt;
                    rem_d = {1'b0, zt[WZ-1:WQ]};
                    zlo_d = zt[WQ-1:0];
                    cnt_d = CW'(WQ - 1);
                    if (bt == '0) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                    end else if (sat_ovf) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        dz_d    = 1'b0;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        dz_d    = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            S_CALC: begin
                rem_d = ge ? (trial - {1'b0, bt_q}) : trial;
                zlo_d = {zlo_q[WQ-2:0], 1'b0};
                q_d   = {q_q[WQ-2:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            zlo_q   <= '0;
            bt_q    <= '0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            zlo_q   <= zlo_d;
            bt_q    <= bt_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.Q         = q_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;
endmodule

// File: tb/tb_div24u_trunc_seq.sv
// Scoreboard bench for div24u_trunc_seq: directed corner cases followed by
// randomized operations with random result back-pressure.
module tb_div24u_trunc_seq;
    localparam int WZ = 24;
    localparam int WB = 12;
    localparam int WQ = 12;

    typedef struct {
        logic [WQ-1:0] q;
        logic          ovf;
        logic          dz;
    } exp_t;

    logic clk;
    logic rst_n;
    div24u_trunc_seq_if #(.WZ(WZ), .WB(WB), .WQ(WQ)) bus ();

    div24u_trunc_seq #(.WZ(WZ), .WB(WB), .WQ(WQ), .KEEP_Z(10), .KEEP_B(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic ready_mode = 1'b0;
    logic ready_val  = 1'b1;
    logic ready_rnd  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.out_ready = ready_mode ? ready_rnd : ready_val;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) ready_rnd = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: truncate both operands, then plain integer division with saturation.
    function automatic exp_t model(input logic [WZ-1:0] z, input logic [WB-1:0] b);
        exp_t   e;
        longint zt, bt;
        zt = longint'(z) & ~longint'((1 << 14) - 1);
        bt = longint'(b) & ~longint'((1 << 7) - 1);
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        if (bt == 0) begin
            e.q  = '1;
            e.dz = 1'b1;
        end else if (zt >= bt * 4096) begin
            e.q   = '1;
            e.ovf = 1'b1;
        end else begin
            e.q = WQ'(zt / bt);
        end
        return e;
    endfunction

    // Monitor: pops on the first cycle a result is presented, then checks it holds.
    initial begin
        logic          have = 1'b0;
        exp_t          held;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 1'b0;
            end else if (bus.out_valid) begin
                chk("in_ready_low_in_done", bus.in_ready, 0);
                if (!have) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("Q", bus.Q, e.q);
                        chk("ovf", bus.ovf, e.ovf);
                        chk("dz", bus.dz, e.dz);
                        chk("latency", cyc - acc_cyc, (e.ovf || e.dz) ? 0 : WQ);
                        held.q = bus.Q; held.ovf = bus.ovf; held.dz = bus.dz;
                        have = 1'b1;
                    end
                end else begin
                    chk("Q_stable", bus.Q, held.q);
                    chk("flags_stable", {bus.ovf, bus.dz}, {held.ovf, held.dz});
                end
                if (bus.out_ready) have = 1'b0;
            end
        end
    end

    task automatic issue(input logic [WZ-1:0] z, input logic [WB-1:0] b, input exp_t e);
        int n = 0;
        @(posedge clk);
        #1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 1, 0);
            return;
        end
        bus.Z = z;
        bus.B = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        sb.push_back(e);
        bus.in_valid = 1'b0;
        bus.Z = WZ'($urandom);
        bus.B = WB'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || !bus.in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0 || !bus.in_ready) chk("done_timeout", 1, 0);
    endtask

    function automatic exp_t mk(input logic [WQ-1:0] q, input logic o, input logic d);
        exp_t e;
        e.q = q; e.ovf = o; e.dz = d;
        return e;
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WZ-1:0] z;
        logic [WB-1:0] b;
        int            n;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.Z = '0;
        bus.B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_Q", bus.Q, 0);
        chk("rst_flags", {bus.ovf, bus.dz}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(24'h00C000, 12'h180, mk(12'h080, 0, 0)); wait_done();
        issue(24'h3FFFFF, 12'h87F, mk(12'h7F8, 0, 0)); wait_done();
        issue(24'h3FC000, 12'h800, mk(12'h7F8, 0, 0)); wait_done();
        issue(24'hFFC000, 12'h080, mk(12'hFFF, 1, 0)); wait_done();
        issue(WZ'($urandom), 12'h07F, mk(12'hFFF, 0, 1)); wait_done();

        // Result stalled by the consumer; new requests must be ignored.
        ready_val = 1'b0;
        issue(24'h00C000, 12'h180, mk(12'h080, 0, 0));
        n = 0;
        while (!bus.out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_out_valid", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.Z = 24'h3FC000;
            bus.B = 12'h800;
            @(posedge clk);
            #1;
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_Q", bus.Q, 12'h080);
        end
        bus.in_valid = 1'b0;
        ready_val = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", bus.out_valid, 0);
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_Q_kept", bus.Q, 12'h080);

        // Reset in the middle of a calculation discards it immediately.
        issue(24'h00C000, 12'h180, mk(12'h080, 0, 0));
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_Q", bus.Q, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(24'h3FC000, 12'h800, mk(12'h7F8, 0, 0)); wait_done();

        ready_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            b = WB'($urandom);
            if ($urandom_range(0, 3) != 0)
                z = {WB'($urandom_range(0, int'(b))), WQ'($urandom)};
            else
                z = WZ'($urandom);
            issue(z, b, model(z, b));
        end
        ready_mode = 1'b0;
        ready_val  = 1'b1;
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
